// File: rtl/fft_reorder_16.sv
// Bit-reversed to natural-order reorder buffer for 16-point FFT frames.
// Ping-pong register banks: one bank fills while the other drains in natural order.
module fft_reorder_16 #(
  parameter int WD = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din_valid,
  input  logic signed [WD-1:0] din_re,
  input  logic signed [WD-1:0] din_im,
  output logic                 dout_valid,
  output logic signed [WD-1:0] dout_re,
  output logic signed [WD-1:0] dout_im,
  output logic                 dout_sof,
  output logic                 dout_eof
);

  function automatic logic [3:0] bitrev4(input logic [3:0] n);
    return {n[0], n[1], n[2], n[3]};
  endfunction

  // Bank select is the MSB of the storage address.
  logic signed [WD-1:0] bank_re_q [32];
  logic signed [WD-1:0] bank_im_q [32];

  logic [3:0] wr_cnt_q, wr_cnt_d;
  logic       wr_bank_q, wr_bank_d;
  logic [3:0] rd_cnt_q, rd_cnt_d;
  logic       rd_bank_q, rd_bank_d;
  logic       rd_active_q, rd_active_d;
  logic       wrap;

  logic                 dout_valid_d, dout_sof_d, dout_eof_d;
  logic signed [WD-1:0] dout_re_d, dout_im_d;

  assign wrap = din_valid && (wr_cnt_q == 4'd15);

  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    wr_bank_d   = wr_bank_q;
    rd_cnt_d    = rd_cnt_q;
    rd_bank_d   = rd_bank_q;
    rd_active_d = rd_active_q;
    if (din_valid) wr_cnt_d = wr_cnt_q + 4'd1;
    if (rd_active_q) begin
      rd_cnt_d = rd_cnt_q + 4'd1;
      if (rd_cnt_q == 4'd15) rd_active_d = 1'b0;
    end
    // A completing frame takes priority so back-to-back reads stay contiguous.
    if (wrap) begin
      wr_bank_d   = ~wr_bank_q;
      rd_active_d = 1'b1;
      rd_cnt_d    = 4'd0;
      rd_bank_d   = wr_bank_q;
    end
  end

  always_comb begin
    dout_valid_d = rd_active_q;
    dout_re_d    = '0;
    dout_im_d    = '0;
    dout_sof_d   = 1'b0;
    dout_eof_d   = 1'b0;
    if (rd_active_q) begin
      dout_re_d  = bank_re_q[{rd_bank_q, rd_cnt_q}];
      dout_im_d  = bank_im_q[{rd_bank_q, rd_cnt_q}];
      dout_sof_d = (rd_cnt_q == 4'd0);
      dout_eof_d = (rd_cnt_q == 4'd15);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_active_q <= 1'b0;
      dout_valid  <= 1'b0;
      dout_re     <= '0;
      dout_im     <= '0;
      dout_sof    <= 1'b0;
      dout_eof    <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_bank_q   <= rd_bank_d;
      rd_active_q <= rd_active_d;
      dout_valid  <= dout_valid_d;
      dout_re     <= dout_re_d;
      dout_im     <= dout_im_d;
      dout_sof    <= dout_sof_d;
      dout_eof    <= dout_eof_d;
    end
  end

  // Storage is never read before being written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (din_valid) begin
      bank_re_q[{wr_bank_q, bitrev4(wr_cnt_q)}] <= din_re;
      bank_im_q[{wr_bank_q, bitrev4(wr_cnt_q)}] <= din_im;
    end
  end

endmodule

// File: tb/tb_fft_reorder_16.sv
// Bench for fft_reorder_16: directed and random frames against a frame-level
// reference that schedules natural-order outputs per clock cycle.
module tb_fft_reorder_16;
  localparam int WD   = 12;
  localparam int NCYC = 4096;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 din_valid;
  logic signed [WD-1:0] din_re, din_im;
  logic                 dout_valid, dout_sof, dout_eof;
  logic signed [WD-1:0] dout_re, dout_im;

  fft_reorder_16 #(.WD(WD)) dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid),
    .din_re(din_re), .din_im(din_im),
    .dout_valid(dout_valid), .dout_re(dout_re), .dout_im(dout_im),
    .dout_sof(dout_sof), .dout_eof(dout_eof)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Expected output per cycle index.
  bit                   sv  [NCYC];
  bit                   ssof[NCYC];
  bit                   seof[NCYC];
  logic signed [WD-1:0] sre [NCYC];
  logic signed [WD-1:0] sim [NCYC];

  logic signed [WD-1:0] fr_re[16];
  logic signed [WD-1:0] fr_im[16];
  int fr_cnt = 0;

  function automatic int rev4(input int k);
    int r = 0;
    for (int b = 0; b < 4; b++)
      if ((k >> b) & 1) r = r + (1 << (3 - b));
    return r;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit v, input int re, input int im, input bit rn);
    rst_n     = rn;
    din_valid = v;
    din_re    = WD'(re);
    din_im    = WD'(im);
    @(posedge clk);
    cyc++;
    if (!rn) begin
      fr_cnt = 0;
      for (int c = cyc; c < NCYC; c++) sv[c] = 1'b0;
    end else if (v) begin
      fr_re[fr_cnt] = WD'(re);
      fr_im[fr_cnt] = WD'(im);
      fr_cnt++;
      if (fr_cnt == 16) begin
        // Arrival n holds X[rev4(n)], so X[k] is arrival rev4(k).
        for (int k = 0; k < 16; k++) begin
          sv[cyc+1+k]   = 1'b1;
          sre[cyc+1+k]  = fr_re[rev4(k)];
          sim[cyc+1+k]  = fr_im[rev4(k)];
          ssof[cyc+1+k] = (k == 0);
          seof[cyc+1+k] = (k == 15);
        end
        fr_cnt = 0;
      end
    end
    #1;
    check("valid", {31'd0, dout_valid}, {31'd0, sv[cyc]});
    check("re",  32'(dout_re), sv[cyc] ? 32'(sre[cyc]) : 32'sd0);
    check("im",  32'(dout_im), sv[cyc] ? 32'(sim[cyc]) : 32'sd0);
    check("sof", {31'd0, dout_sof}, {31'd0, sv[cyc] & ssof[cyc]});
    check("eof", {31'd0, dout_eof}, {31'd0, sv[cyc] & seof[cyc]});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b1);
  endtask

  initial begin
    for (int c = 0; c < NCYC; c++) sv[c] = 1'b0;
    rst_n = 1'b0; din_valid = 1'b0; din_re = '0; din_im = '0;
    #1;
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b0);
    idle(2);

    // Single frame: re=n, im=-n.
    for (int n = 0; n < 16; n++) step(1'b1, n, -n, 1'b1);
    idle(20);

    // Back-to-back frames A and B.
    for (int n = 0; n < 16; n++) step(1'b1, n, n + 1, 1'b1);
    for (int n = 0; n < 16; n++) step(1'b1, n + 100, -n - 100, 1'b1);
    idle(36);

    // Gapped input, valid every other cycle.
    for (int n = 0; n < 16; n++) begin
      step(1'b1, n, -n, 1'b1);
      if (n != 15) step(1'b0, 0, 0, 1'b1);
    end
    idle(20);

    // Reset mid-frame.
    for (int n = 0; n < 7; n++) step(1'b1, 900 + n, 900 + n, 1'b1);
    step(1'b0, 0, 0, 1'b0);
    for (int n = 0; n < 16; n++) step(1'b1, n + 50, n - 50, 1'b1);
    idle(20);

    // Reset while X[5] is on the output.
    for (int n = 0; n < 16; n++) step(1'b1, n + 200, n + 300, 1'b1);
    idle(6);
    step(1'b0, 0, 0, 1'b0);
    idle(20);

    // Extremes.
    for (int n = 0; n < 16; n++) step(1'b1, -2048, 2047, 1'b1);
    idle(20);

    // Random frames with random gaps and occasional back-to-back runs.
    for (int f = 0; f < 6; f++) begin
      for (int n = 0; n < 16; n++) begin
        while ($urandom_range(0, 3) == 0) step(1'b0, 0, 0, 1'b1);
        step(1'b1, int'($urandom_range(0, 4095)) - 2048,
             int'($urandom_range(0, 4095)) - 2048, 1'b1);
      end
    end
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fft_reorder_16.md
FFT_REORDER_16 -- requirements
Module: fft_reorder_16

Interface
REQ-001 SHALL have parameter WD, default 12: width of each signed real/imaginary sample.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low, sampled on rising clk.
REQ-004 SHALL have port din_valid  input  1  qualifies din_re/din_im as one bit-reversed-order FFT output sample.
REQ-005 SHALL have port din_re  input  WD signed  real part of input sample.
REQ-006 SHALL have port din_im  input  WD signed  imaginary part of input sample.
REQ-007 SHALL have port dout_valid  output  1  high when dout_re/dout_im carry a natural-order sample.
REQ-008 SHALL have port dout_re  output  WD signed  real part of output sample X[k].
REQ-009 SHALL have port dout_im  output  WD signed  imaginary part of output sample X[k].
REQ-010 SHALL have port dout_sof  output  1  high with dout_valid for X[0] of each frame.
REQ-011 SHALL have port dout_eof  output  1  high with dout_valid for X[15] of each frame.

Function
REQ-012 SHALL convert 16-sample frames from bit-reversed order (arrival n = X[bitrev4(n)]) to natural order X[0]..X[15].
REQ-013 SHALL hold two 16-entry banks of {re,im} registers (ping-pong): one written, one read.
REQ-014 SHALL keep 4-bit write counter wr_cnt; each clk with din_valid=1 writes the sample to write bank at address bitrev4(wr_cnt) = {wr_cnt[0],wr_cnt[1],wr_cnt[2],wr_cnt[3]}, then increments wr_cnt.
REQ-015 SHALL hold wr_cnt and write nothing on cycles with din_valid=0; gaps of any length within a frame are allowed.
REQ-016 SHALL, on the edge where wr_cnt wraps 15->0, toggle the write-bank select and set rd_active with rd_cnt=0 on the just-completed bank.
REQ-017 SHALL, while rd_active, register bank[rd_bank][rd_cnt] onto dout_re/dout_im with dout_valid=1 each edge, incrementing rd_cnt; rd_active clears after rd_cnt=15 is output.
REQ-018 SHALL output X[k] on the (k+1)-th edge after the edge that wrote the frame's 16th sample (first-output latency 1 cycle); 16 outputs on consecutive cycles, no gaps.
REQ-019 SHALL assert dout_sof only with rd_cnt=0 output and dout_eof only with rd_cnt=15 output.
REQ-020 SHALL drive dout_re=dout_im=0 and dout_sof=dout_eof=0 on any cycle dout_valid=0.
REQ-021 SHALL support back-to-back frames at full rate: a frame completing the same edge the previous read outputs X[15] starts its read on the next edge, giving 32 contiguous valid outputs.
REQ-022 SHALL never lose data: input rate <= 1/cycle guarantees read of bank A (16 cycles) ends before bank A is rewritten; no overflow flag is required.
REQ-023 SHALL pass sample values unmodified (no scaling, rounding or sign change); width WD in = WD out.
REQ-024 SHALL be fully synchronous with no combinational path from din_* to dout_*.

Reset
REQ-025 SHALL, while rst_n=0 at a clk edge, set wr_cnt=0, rd_cnt=0, rd_active=0, write-bank select=0, dout_valid=0, dout_sof=0, dout_eof=0, dout_re=0, dout_im=0.
REQ-026 SHALL not require bank storage to be reset; contents are never output before being written after reset.
REQ-027 SHALL, on reset mid-frame or mid-read, discard the partial frame and any in-progress read; first frame after reset starts at wr_cnt=0.

Verification
REQ-028 Single frame: din_re=n, din_im=-n for n=0..15 on 16 consecutive cycles -> dout_re sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 starting 1 cycle after last input, dout_im = negated values, sof on first, eof on last.
REQ-029 Back-to-back: frames A (re=n) and B (re=n+100) contiguous, 32 inputs -> 32 contiguous valid outputs, B's sequence 100,108,104,... immediately after A's 15.
REQ-030 Gapped input: frame with din_valid low every other cycle (31 cycles) -> same output order as REQ-028, output burst of 16 contiguous cycles begins 1 cycle after 16th valid input.
REQ-031 Reset mid-frame: 7 samples, rst_n=0 one cycle, then full frame re=n+50 -> only one 16-sample output burst, values 50,58,54,...,65; no stale samples.
REQ-032 Reset mid-read: assert rst_n=0 during output of X[5] -> dout_valid=0 and dout_re=0 the following cycle, no further outputs until a new complete frame.
REQ-033 Extremes: WD=12, samples re=-2048, im=2047 at all n -> every output re=-2048, im=2047, exact.
